// File: rtl/snake_collision_unit.sv
// snake_collision_unit: checks the snake head's next move against the
// playfield walls and against a shift-register history of body positions.
// One history entry is compared per clock while the check runs.
// Optional build macro: COLL_WRAP_EN makes boundary moves wrap around the
// playfield instead of reporting a wall hit.
module snake_collision_unit #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           push,
    input  logic           clear,
    input  logic [X_W-1:0] regx,
    input  logic [Y_W-1:0] regy,
    input  logic [1:0]     direction,
    output logic           busy,
    output logic           done,
    output logic           collision,
    output logic           wall_hit,
    output logic           self_hit,
    output logic [7:0]     len
);

    localparam int             IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [X_W-1:0] XM      = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YM      = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_ONE   = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);
    localparam logic [7:0]     DEPTH_L = 8'(DEPTH);

    typedef enum logic [1:0] {IDLE, WALL, SCAN, DONE} state_t;

    state_t         state;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [1:0]     head_dir;
    logic [X_W-1:0] next_x;
    logic [Y_W-1:0] next_y;
    logic [7:0]     idx;

    // History storage: index 0 is the newest entry; never reset, since
    // only indices below len are ever compared.
    logic [X_W-1:0] hist_x [DEPTH];
    logic [Y_W-1:0] hist_y [DEPTH];

    logic           wall_c;
    logic [X_W-1:0] step_x;
    logic [Y_W-1:0] step_y;
    logic           shift_en;
    logic           match;

    // A push only lands in IDLE, and loses to start and clear.
    assign shift_en = (state == IDLE) && push && !start && !clear;
    assign match    = (hist_x[idx[IDX_W-1:0]] == next_x) &&
                      (hist_y[idx[IDX_W-1:0]] == next_y);

    // Next head position and boundary test for the latched move.
    always_comb begin
        wall_c = 1'b0;
        step_x = head_x;
        step_y = head_y;
`ifdef COLL_WRAP_EN
        case (head_dir)
            2'd0:    step_x = (head_x == '0) ? XM : head_x - X_ONE;
            2'd1:    step_x = (head_x >= XM) ? '0 : head_x + X_ONE;
            2'd2:    step_y = (head_y == '0) ? YM : head_y - Y_ONE;
            default: step_y = (head_y >= YM) ? '0 : head_y + Y_ONE;
        endcase
`else
        case (head_dir)
            2'd0: begin
                wall_c = (head_x == '0);
                step_x = head_x - X_ONE;
            end
            2'd1: begin
                wall_c = (head_x >= XM);
                step_x = head_x + X_ONE;
            end
            2'd2: begin
                wall_c = (head_y == '0);
                step_y = head_y - Y_ONE;
            end
            default: begin
                wall_c = (head_y >= YM);
                step_y = head_y + Y_ONE;
            end
        endcase
`endif
    end

    // Shift the new entry in at index 0; the oldest falls off the end.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            hist_x[0] <= regx;
            hist_y[0] <= regy;
            for (int i = 1; i < DEPTH; i++) begin
                hist_x[i] <= hist_x[i-1];
                hist_y[i] <= hist_y[i-1];
            end
        end
    end

    // Control FSM with registered status outputs and the entry counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            wall_hit  <= 1'b0;
            self_hit  <= 1'b0;
            head_x    <= '0;
            head_y    <= '0;
            head_dir  <= '0;
            next_x    <= '0;
            next_y    <= '0;
        end else if (clear) begin
            state     <= IDLE;
            len       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            wall_hit  <= 1'b0;
            self_hit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        head_x    <= regx;
                        head_y    <= regy;
                        head_dir  <= direction;
                        collision <= 1'b0;
                        wall_hit  <= 1'b0;
                        self_hit  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WALL;
                    end else if (push && len != DEPTH_L) begin
                        len <= len + 8'd1;
                    end
                end
                WALL: begin
                    if (wall_c) begin
                        wall_hit  <= 1'b1;
                        collision <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        next_x <= step_x;
                        next_y <= step_y;
                        idx    <= '0;
                        if (len == 8'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (match) begin
                        self_hit  <= 1'b1;
                        collision <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (idx == len - 8'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
